pio_pin_allocator: RTL and testbench
====================================

// Module: pio_pin_allocator
// PURPOSE
//  Owns the per-pin core_select table driving core_output_arbitrator in pio_chip.
//  PIO cores request claim/release of GPIO pin sets over a valid/ready port.
//  Requests are round-robin arbitrated and checked for ownership conflicts.
//  The block answers each core with a one-cycle response carrying the result.
//  Replaces the static core_select wiring with a sequenced, conflict-free pin map.
// PARAMETERS
//  NUM_CORES  4                    number of requesting PIO cores
//  NUM_PINS   32                   number of GPIO pins managed
//  CORE_W     $clog2(NUM_CORES)    width of one core_select entry
// PORTS
//  clk            in   1                    single clock, all state on rising edge
//  rst            in   1                    reset, asynchronous, active-low
//  req_valid      in   NUM_CORES            per-core request valid; hold until req_ready
//  req_claim      in   NUM_CORES            per-core op: 1=claim, 0=release
//  req_mask       in   [NUM_CORES][NUM_PINS] per-core pin mask
//  req_ready      out  NUM_CORES            one-hot accept pulse
//  force_release  in   NUM_CORES            release every pin owned by core c
//  resp_valid     out  NUM_CORES            one-hot, 1-cycle response to accepted core
//  resp_granted   out  1                    qualifies resp_valid: 1=op applied
//  resp_conflict  out  NUM_PINS             requested pins owned by another core
//  core_select    out  [NUM_PINS][CORE_W]   registered owner per pin (0 when unowned)
//  pin_owned      out  NUM_PINS             1 = pin currently claimed
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, rr_ptr=0.
//   - All outputs 0: core_select all 0, pin_owned=0, req_ready=0, resp_*=0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE. One request per 3 cycles max.
//  IDLE:
//   - If any req_valid, the winner is the first set bit at or after rr_ptr (circular).
//   - Assert req_ready[winner] (combinational, this cycle only).
//   - Latch winner/op/mask. rr_ptr <= (winner+1) mod NUM_CORES. Go to EXEC.
//   - No valid: stay in IDLE.
//  EXEC:
//   - conflict = mask & pin_owned & (owner != winner), using the registered table.
//   - Claim, conflict==0: owned|=mask, owner[mask]=winner, granted=1.
//   - Claim, conflict!=0: table unchanged, granted=0 (all-or-nothing).
//   - Release: pins in mask owned by winner are cleared (owner=0); others ignored.
//     granted=1; conflict reported for information.
//   - Empty mask: granted=1, no change.
//   - Latch granted/conflict into resp regs. Go to RESP.
//  RESP:
//   - resp_valid[winner]=1 for exactly this cycle; resp_granted/resp_conflict valid here.
//   - Go to IDLE.
//   - Table update is visible on core_select/pin_owned in the same cycle as resp_valid.
//   - resp_granted/resp_conflict are 0 outside RESP.
//  force_release (any state, any cycle):
//   - At the next edge, clears all pins owned by core c; applied after the EXEC write.
//   - An EXEC conflict is computed against the pre-edge table.
//   - A simultaneous claim and force_release by the same core nets to released.
//   - resp_valid is still issued to a winner that is force-released.
//  Requester deasserting req_valid after acceptance has no effect; the request is latched.
//  Pins with pin_owned=0 have core_select=0; the arbitrator relies on core_drive gating.
// TESTING
//  1. Reset assertion:
//     core_select all 0, pin_owned=0, no ready/resp.
//     rst pulsed low mid-cycle clears immediately.
//  2. Core2 claims mask 0xF0:
//     req_ready[2] @t0, resp_valid[2] @t2, granted=1.
//     core_select[7:4]=2, pin_owned=0xF0.
//  3. Then core1 claims 0x30:
//     granted=0, resp_conflict=0x30, pin_owned stays 0xF0.
//  4. rr_ptr=3; cores 0,1,3 request together and hold:
//     accepts ordered 3,0,1 at t0, t3, t6.
//  5. force_release[2] during core1 EXEC claim of 0x10:
//     granted=0, conflict=0x10, pin_owned=0 after.
//  6. rst low during EXEC:
//     no resp_valid, table cleared, FSM in IDLE on release.

Source files
------------

// File: rtl/pio_pin_allocator.sv
// Per-pin ownership table: round-robin claim/release arbitration with conflict checks.
// Accept->response is 2 cycles (one request per 3 cycles); requesters hold req_valid until req_ready.
module pio_pin_allocator #(
  parameter int NUM_CORES = 4,
  parameter int NUM_PINS  = 32,
  parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_CORES-1:0]                 req_valid_i,
  input  logic [NUM_CORES-1:0]                 req_claim_i,
  input  logic [NUM_CORES-1:0][NUM_PINS-1:0]   req_mask_i,
  output logic [NUM_CORES-1:0]                 req_ready_o,
  input  logic [NUM_CORES-1:0]                 force_release_i,
  output logic [NUM_CORES-1:0]                 resp_valid_o,
  output logic                                 resp_granted_o,
  output logic [NUM_PINS-1:0]                  resp_conflict_o,
  output logic [NUM_PINS-1:0][CORE_W-1:0]      core_select_o,
  output logic [NUM_PINS-1:0]                  pin_owned_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [CORE_W-1:0]   core;
    logic                claim;
    logic [NUM_PINS-1:0] mask;
  } req_t;

  state_e                          state_q, state_d;
  logic [CORE_W-1:0]               rr_q, rr_d;
  req_t                            req_q, req_d;
  logic                            gnt_q, gnt_d;
  logic [NUM_PINS-1:0]             conf_q, conf_d;
  logic [NUM_PINS-1:0]             owned_q, owned_d, owned_x;
  logic [NUM_PINS-1:0][CORE_W-1:0] sel_q, sel_d, sel_x;
  logic                            found;
  logic [CORE_W-1:0]               pick;
  logic [NUM_PINS-1:0]             conflict;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && req_valid_i[(int'(rr_q) + i) % NUM_CORES]) begin
        found = 1'b1;
        pick  = CORE_W'((int'(rr_q) + i) % NUM_CORES);
      end
    end
  end

  always_comb begin
    conflict = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      conflict[p] = req_q.mask[p] & owned_q[p] & (sel_q[p] != req_q.core);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    req_d       = req_q;
    gnt_d       = gnt_q;
    conf_d      = conf_q;
    owned_x     = owned_q;
    sel_x       = sel_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_o[pick] = 1'b1;
          req_d.core        = pick;
          req_d.claim       = req_claim_i[pick];
          req_d.mask        = req_mask_i[pick];
          rr_d              = (pick == CORE_W'(NUM_CORES - 1)) ? '0 : pick + CORE_W'(1);
          state_d           = EXEC;
        end
      end
      EXEC: begin
        conf_d = conflict;
        if (req_q.claim) begin
          // All-or-nothing: any foreign-owned pin in the mask rejects the whole claim.
          gnt_d = (conflict == '0);
          if (conflict == '0) begin
            for (int p = 0; p < NUM_PINS; p++) begin
              if (req_q.mask[p]) begin
                owned_x[p] = 1'b1;
                sel_x[p]   = req_q.core;
              end
            end
          end
        end else begin
          gnt_d = 1'b1;
          for (int p = 0; p < NUM_PINS; p++) begin
            if (req_q.mask[p] && owned_q[p] && (sel_q[p] == req_q.core)) begin
              owned_x[p] = 1'b0;
              sel_x[p]   = '0;
            end
          end
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Force-release lands after the EXEC write so a same-cycle claim by that core nets to released.
  always_comb begin
    owned_d = owned_x;
    sel_d   = sel_x;
    for (int p = 0; p < NUM_PINS; p++) begin
      if (owned_x[p] && force_release_i[sel_x[p]]) begin
        owned_d[p] = 1'b0;
        sel_d[p]   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      req_q   <= '0;
      gnt_q   <= 1'b0;
      conf_q  <= '0;
      owned_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      conf_q  <= conf_d;
      owned_q <= owned_d;
      sel_q   <= sel_d;
    end
  end

  assign resp_valid_o    = (state_q == RESP) ? (NUM_CORES'(1) << req_q.core) : '0;
  assign resp_granted_o  = (state_q == RESP) && gnt_q;
  assign resp_conflict_o = (state_q == RESP) ? conf_q : '0;
  assign core_select_o   = sel_q;
  assign pin_owned_o     = owned_q;

endmodule

// File: tb/tb_pio_pin_allocator.sv
// Bench for pio_pin_allocator: transaction-level ownership model checked every cycle plus directed literals.
module tb_pio_pin_allocator;
  localparam int NC = 4;
  localparam int NP = 32;
  localparam int CW = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NC-1:0]          req_valid = '0;
  logic [NC-1:0]          req_claim = '0;
  logic [NC-1:0][NP-1:0]  req_mask = '0;
  logic [NC-1:0]          force_release = '0;
  logic [NC-1:0]          req_ready;
  logic [NC-1:0]          resp_valid;
  logic                   resp_granted;
  logic [NP-1:0]          resp_conflict;
  logic [NP-1:0][CW-1:0]  core_select;
  logic [NP-1:0]          pin_owned;

  pio_pin_allocator #(.NUM_CORES(NC), .NUM_PINS(NP), .CORE_W(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_claim_i    (req_claim),
    .req_mask_i     (req_mask),
    .req_ready_o    (req_ready),
    .force_release_i(force_release),
    .resp_valid_o   (resp_valid),
    .resp_granted_o (resp_granted),
    .resp_conflict_o(resp_conflict),
    .core_select_o  (core_select),
    .pin_owned_o    (pin_owned)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  bit done   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: owner per pin (-1 = free), plus the one transaction in flight and its phase.
  int            m_owner [NP];
  int            m_phase, m_rr, m_win;
  bit            m_claim, m_gnt;
  logic [NP-1:0] m_mask, m_conf;

  function automatic void m_reset();
    foreach (m_owner[p]) m_owner[p] = -1;
    m_phase = 0; m_rr = 0; m_win = 0; m_claim = 0; m_gnt = 0;
    m_mask = '0; m_conf = '0;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < NC; k++) begin
      if (req_valid[(m_rr + k) % NC]) return (m_rr + k) % NC;
    end
    return -1;
  endfunction

  function automatic void m_step();
    int w;
    case (m_phase)
      0: begin
        w = m_pick();
        if (w >= 0) begin
          m_win = w; m_claim = req_claim[w]; m_mask = req_mask[w];
          m_rr = (w + 1) % NC; m_phase = 1;
        end
      end
      1: begin
        m_conf = '0;
        foreach (m_owner[p])
          if (m_mask[p] && m_owner[p] >= 0 && m_owner[p] != m_win) m_conf[p] = 1'b1;
        if (m_claim) begin
          m_gnt = (m_conf == '0);
          if (m_gnt) foreach (m_owner[p]) if (m_mask[p]) m_owner[p] = m_win;
        end else begin
          m_gnt = 1;
          foreach (m_owner[p]) if (m_mask[p] && m_owner[p] == m_win) m_owner[p] = -1;
        end
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    foreach (m_owner[p])
      if (m_owner[p] >= 0 && force_release[m_owner[p]]) m_owner[p] = -1;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  always @(negedge clk) begin
    logic [NC-1:0]         e_rdy, e_rv;
    logic [NP-1:0]         e_own, e_conf;
    logic [NP-1:0][CW-1:0] e_sel;
    int                    w;
    if (!done) begin
      w      = m_pick();
      e_rdy  = (m_phase == 0 && w >= 0) ? NC'(1) << w : '0;
      e_rv   = (m_phase == 2) ? NC'(1) << m_win : '0;
      e_conf = (m_phase == 2) ? m_conf : '0;
      e_own  = '0;
      e_sel  = '0;
      foreach (m_owner[p]) if (m_owner[p] >= 0) begin e_own[p] = 1'b1; e_sel[p] = CW'(m_owner[p]); end
      chk("model_req_ready", 64'(req_ready), 64'(e_rdy));
      chk("model_resp_valid", 64'(resp_valid), 64'(e_rv));
      chk("model_resp_granted", 64'(resp_granted), 64'(m_phase == 2 && m_gnt));
      chk("model_resp_conflict", 64'(resp_conflict), 64'(e_conf));
      chk("model_pin_owned", 64'(pin_owned), 64'(e_own));
      chk("model_core_select", 64'(core_select), 64'(e_sel));
    end
  end

  // One request through accept/EXEC/RESP; fx is driven as force_release during the EXEC cycle.
  task automatic do_req(input int c, input logic cl, input logic [NP-1:0] m, input logic [NC-1:0] fx,
                        output int waits, output logic g, output logic [NP-1:0] cf,
                        output logic [NP-1:0] own, output logic [63:0] sel);
    bit seen = 0;
    waits = 0;
    req_valid[c] = 1'b1; req_claim[c] = cl; req_mask[c] = m;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (req_ready[c]) seen = 1; else waits++;
      @(posedge clk); #1;
    end
    req_valid[c] = 1'b0;
    chk("accept", 64'(seen), 64'd1);
    force_release = fx;
    @(negedge clk);
    chk("no_resp_in_exec", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    force_release = '0;
    @(negedge clk);
    chk("resp_valid_onehot", 64'(resp_valid), 64'(NC'(1) << c));
    g = resp_granted; cf = resp_conflict; own = pin_owned; sel = 64'(core_select);
    @(posedge clk); #1;
  endtask

  initial begin
    int            w, nacc, seen_rv;
    logic          g;
    logic [NP-1:0] cf, own;
    logic [63:0]   sel;
    int            acc_core [3];
    int            acc_cyc  [3];
    logic [NC-1:0] rdy;

    // Reset state
    #12;
    chk("rst_pin_owned", 64'(pin_owned), 64'd0);
    chk("rst_core_select", 64'(core_select), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Core 2 claims 0xF0
    do_req(2, 1'b1, 32'h0000_00F0, '0, w, g, cf, own, sel);
    chk("c2_claim_wait", 64'(w), 64'd0);
    chk("c2_claim_granted", 64'(g), 64'd1);
    chk("c2_claim_owned", 64'(own), 64'h0F0);
    chk("c2_claim_select", sel, 64'hAA00);

    // Core 1 conflicting claim 0x30
    do_req(1, 1'b1, 32'h0000_0030, '0, w, g, cf, own, sel);
    chk("c1_conflict_granted", 64'(g), 64'd0);
    chk("c1_conflict_mask", 64'(cf), 64'h30);
    chk("c1_conflict_owned", 64'(own), 64'hF0);

    // Empty-mask claim by core 2 moves the pointer to 3
    do_req(2, 1'b1, 32'h0, '0, w, g, cf, own, sel);
    chk("empty_granted", 64'(g), 64'd1);
    chk("empty_owned", 64'(own), 64'hF0);

    // Cores 0,1,3 request together
    req_claim = 4'b1001;
    req_mask[0] = 32'h0000_0001;
    req_mask[1] = 32'h0000_00F0;
    req_mask[3] = 32'h0000_0100;
    req_valid = 4'b1011;
    nacc = 0;
    foreach (acc_core[i]) begin acc_core[i] = -1; acc_cyc[i] = 0; end
    for (int n = 0; n < 30 && req_valid != '0; n++) begin
      @(negedge clk);
      rdy = req_ready;
      for (int c = 0; c < NC; c++)
        if (rdy[c] && req_valid[c] && nacc < 3) begin acc_core[nacc] = c; acc_cyc[nacc] = cyc; nacc++; end
      @(posedge clk); #1;
      req_valid = req_valid & ~rdy;
    end
    chk("rr_all_accepted", 64'(req_valid), 64'd0);
    chk("rr_first", 64'(acc_core[0]), 64'd3);
    chk("rr_second", 64'(acc_core[1]), 64'd0);
    chk("rr_third", 64'(acc_core[2]), 64'd1);
    chk("rr_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
    chk("rr_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    @(negedge clk);
    @(negedge clk);
    chk("rel_foreign_valid", 64'(resp_valid), 64'b0010);
    chk("rel_foreign_granted", 64'(resp_granted), 64'd1);
    chk("rel_foreign_conflict", 64'(resp_conflict), 64'hF0);
    chk("rel_foreign_owned", 64'(pin_owned), 64'h1F1);
    @(posedge clk); #1;

    // Force-release cores 0 and 3 while idle
    force_release = 4'b1001;
    @(posedge clk); #1;
    force_release = '0;
    @(negedge clk);
    chk("idle_force_owned", 64'(pin_owned), 64'hF0);
    @(posedge clk); #1;

    // Force-release of core 2 during core 1's claim of 0x10
    do_req(1, 1'b1, 32'h0000_0010, 4'b0100, w, g, cf, own, sel);
    chk("force_exec_granted", 64'(g), 64'd0);
    chk("force_exec_conflict", 64'(cf), 64'h10);
    chk("force_exec_owned", 64'(own), 64'd0);

    // Claim plus force-release of the same core nets to released
    do_req(3, 1'b1, 32'h0000_0300, 4'b1000, w, g, cf, own, sel);
    chk("self_force_granted", 64'(g), 64'd1);
    chk("self_force_owned", 64'(own), 64'd0);

    // Core 0 claims then partially releases; core 2 claims disjoint pins
    do_req(0, 1'b1, 32'h0000_00FF, '0, w, g, cf, own, sel);
    chk("c0_claim_owned", 64'(own), 64'hFF);
    chk("c0_claim_select", sel, 64'd0);
    do_req(0, 1'b0, 32'h0000_000F, '0, w, g, cf, own, sel);
    chk("c0_release_granted", 64'(g), 64'd1);
    chk("c0_release_owned", 64'(own), 64'hF0);
    do_req(2, 1'b1, 32'h0000_0F00, '0, w, g, cf, own, sel);
    chk("c2_disjoint_owned", 64'(own), 64'hFF0);
    chk("c2_disjoint_select", sel, 64'hAA_0000);

    // Reset pulsed during EXEC
    req_valid[1] = 1'b1; req_claim[1] = 1'b1; req_mask[1] = 32'hFFFF_0000;
    @(negedge clk);
    chk("rst_exec_accept", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pin_owned", 64'(pin_owned), 64'd0);
    chk("midrst_core_select", 64'(core_select), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    seen_rv = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid != '0) seen_rv++;
    end
    chk("midrst_no_resp", 64'(seen_rv), 64'd0);
    @(posedge clk); #1;
    do_req(0, 1'b1, 32'h0000_0003, '0, w, g, cf, own, sel);
    chk("post_rst_idle_wait", 64'(w), 64'd0);
    chk("post_rst_granted", 64'(g), 64'd1);
    chk("post_rst_owned", 64'(own), 64'h3);

    done = 1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
